// File: rtl/seq_gen_multi.sv
// -----------------------------------------------------------------------------
// seq_gen_multi
//
// Multi-mode sequence generator. Computes the Nth term of a Fibonacci,
// triangle or arithmetic sequence, one WIDTH-bit add per clock. A single
// start/done handshake launches a request; overflow and error indications
// stay set until 'clear'.
//
// Optional feature macro: SEQ_GEN_ARITH_EN
//   defined     : mode 2'b10 (arithmetic, data_in + N*step) is available.
//   not defined : 'step' is ignored and mode 2'b10 is rejected as illegal.
//
// Parameters
//   WIDTH    datapath / result width (>= 8)
//   ORDER_W  width of 'order' (<= WIDTH)
//
// Ports
//   clk       in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   start     in   request, sampled only in IDLE
//   clear     in   abort / acknowledge, returns to IDLE from any state
//   mode      in   00 Fibonacci, 01 triangle, 10 arithmetic, 11 reserved
//   order     in   term index N
//   data_in   in   seed / initial value
//   step      in   arithmetic increment
//   busy      out  high while iterating
//   done      out  one-cycle pulse, data_out holds the result
//   data_out  out  registered result (all ones on overflow, zero on error)
//   overflow  out  sticky carry-out of an add
//   error     out  sticky illegal-request flag
// -----------------------------------------------------------------------------
module seq_gen_multi #(
    parameter int WIDTH   = 64,
    parameter int ORDER_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               clear,
    input  logic [1:0]         mode,
    input  logic [ORDER_W-1:0] order,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [WIDTH-1:0]   step,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   data_out,
    output logic               overflow,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_DONE = 3'd2,
        S_OVF  = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    localparam logic [1:0] MODE_FIB   = 2'b00;
    localparam logic [1:0] MODE_TRI   = 2'b01;
    localparam logic [1:0] MODE_ARITH = 2'b10;

    localparam logic [WIDTH-1:0]   ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ORDER_W-1:0] ZERO_O = {ORDER_W{1'b0}};
    localparam logic [ORDER_W-1:0] ONE_O  = {{(ORDER_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [ORDER_W-1:0] tgt_q, tgt_d;       // iterations required (T)
    logic [ORDER_W-1:0] cnt_q, cnt_d;       // iterations performed
    logic [WIDTH-1:0]   x_q, x_d;           // fib: previous term, tri: k, arith: step
    logic [WIDTH-1:0]   y_q, y_d;           // running result in every mode
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic               error_q, error_d;

    logic [WIDTH:0]     sum_s;
    logic               mode_bad_s;
    logic               req_illegal_s;
    logic               arith_en_s;
    logic [WIDTH-1:0]   step_s;

`ifdef SEQ_GEN_ARITH_EN
    assign arith_en_s = 1'b1;
    assign step_s     = step;
`else
    // Port kept for pin compatibility; the reduction only marks it consumed.
    logic unused_step_s;
    assign unused_step_s = ^step;
    assign arith_en_s    = 1'b0;
    assign step_s        = ZERO_W;
`endif

    // Every mode reduces to y + x, so one adder with carry-out serves all.
    assign sum_s = {1'b0, x_q} + {1'b0, y_q};

    // Per-mode legality of the request presented with start.
    always_comb begin
        case (mode)
            MODE_FIB:   mode_bad_s = (data_in == ZERO_W);
            MODE_TRI:   mode_bad_s = 1'b0;
            MODE_ARITH: mode_bad_s = ~arith_en_s;
            default:    mode_bad_s = 1'b1;
        endcase
    end

    assign req_illegal_s = mode_bad_s | (order == ZERO_O);

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        tgt_d      = tgt_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        data_out_d = data_out_q;
        overflow_d = overflow_q;
        error_d    = error_q;

        if (clear) begin
            // clear outranks start and aborts any computation in flight
            state_d    = S_IDLE;
            data_out_d = ZERO_W;
            overflow_d = 1'b0;
            error_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_d     = mode;
                        cnt_d      = ZERO_O;
                        data_out_d = ZERO_W;
                        y_d        = data_in;
                        case (mode)
                            MODE_FIB: begin
                                x_d   = ZERO_W;
                                tgt_d = order - ONE_O;
                            end
                            MODE_TRI: begin
                                x_d   = ONE_W;
                                tgt_d = order;
                            end
                            default: begin
                                x_d   = step_s;
                                tgt_d = order;
                            end
                        endcase
                        if (req_illegal_s) begin
                            state_d = S_ERR;
                            error_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                S_RUN: begin
                    if (cnt_q == tgt_q) begin
                        data_out_d = y_q;
                        state_d    = S_DONE;
                    end else if (sum_s[WIDTH]) begin
                        state_d    = S_OVF;
                        overflow_d = 1'b1;
                        data_out_d = ONES_W;
                    end else begin
                        y_d   = sum_s[WIDTH-1:0];
                        cnt_d = cnt_q + ONE_O;
                        case (mode_q)
                            MODE_FIB: x_d = y_q;
                            MODE_TRI: x_d = x_q + ONE_W;
                            default:  x_d = x_q;
                        endcase
                    end
                end

                S_DONE: state_d = S_IDLE;
                S_OVF:  state_d = S_OVF;
                S_ERR:  state_d = S_ERR;

                default: begin
                    state_d    = S_IDLE;
                    data_out_d = ZERO_W;
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'b00;
            tgt_q      <= ZERO_O;
            cnt_q      <= ZERO_O;
            x_q        <= ZERO_W;
            y_q        <= ZERO_W;
            data_out_q <= ZERO_W;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            tgt_q      <= tgt_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign overflow = overflow_q;
    assign error    = error_q;

endmodule

// File: tb/tb_seq_gen_multi.sv
// -----------------------------------------------------------------------------
// tb_seq_gen_multi
//
// Scoreboard bench for seq_gen_multi. Two instances: WIDTH=64/ORDER_W=16 and
// WIDTH=8/ORDER_W=8. The driver computes each expected response (kind, value,
// cycle) from closed-form sequence formulas and queues it; a negedge monitor
// pops and compares whenever an instance raises done, overflow or error.
// -----------------------------------------------------------------------------
module tb_seq_gen_multi;

    localparam logic [1:0] K_DONE = 2'd0;
    localparam logic [1:0] K_OVF  = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
`ifdef SEQ_GEN_ARITH_EN
    localparam bit ARITH_EN = 1'b1;
`else
    localparam bit ARITH_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  kind;
        logic [63:0] val;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0, clear = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [15:0] order_i = 16'd0;
    logic [63:0] data_i = 64'd0, step_i = 64'd0;

    logic        busy0, done0, ovf0, err0;
    logic [63:0] dout0;
    logic        busy1, done1, ovf1, err1;
    logic [7:0]  dout1;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = 32'd0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [127:0] fib [0:100];
    logic        ovf0_p = 1'b0, err0_p = 1'b0, ovf1_p = 1'b0, err1_p = 1'b0;

    seq_gen_multi #(.WIDTH(64), .ORDER_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .clear(clear),
        .mode(mode_i), .order(order_i), .data_in(data_i), .step(step_i),
        .busy(busy0), .done(done0), .data_out(dout0), .overflow(ovf0), .error(err0)
    );

    seq_gen_multi #(.WIDTH(8), .ORDER_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .clear(clear),
        .mode(mode_i), .order(order_i[7:0]), .data_in(data_i[7:0]), .step(step_i[7:0]),
        .busy(busy1), .done(done1), .data_out(dout1), .overflow(ovf1), .error(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic logic [3:0] flags(input int d);
        if (d == 0) return {busy0, done0, ovf0, err0};
        else        return {busy1, done1, ovf1, err1};
    endfunction

    function automatic logic [63:0] dout(input int d);
        if (d == 0) return dout0;
        else        return {56'd0, dout1};
    endfunction

    function automatic logic ev(input int d);
        logic [3:0] f;
        f = flags(d);
        return f[2] | f[1] | f[0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected response from the sequence formulas:
    //   Fibonacci  seed*F(N), done after N edges, j-th add yields seed*F(j+1)
    //   triangle   seed + N(N+1)/2, done after N+1 edges, j-th add yields seed + j(j+1)/2
    //   arithmetic seed + N*step,   done after N+1 edges, j-th add yields seed + j*step
    function automatic void model(input int d, input logic [1:0] md, input int n,
                                  input logic [63:0] sd, input logic [63:0] st,
                                  output logic [1:0] kind, output logic [63:0] val,
                                  output int delta);
        logic [127:0] lim, s, stp, term, jj, top;
        lim  = (d == 0) ? (128'd1 << 64) : (128'd1 << 8);
        s    = (d == 0) ? {64'd0, sd} : {120'd0, sd[7:0]};
        stp  = (d == 0) ? {64'd0, st} : {120'd0, st[7:0]};
        top  = lim - 128'd1;
        kind = K_DONE;
        val  = 64'd0;
        delta = 0;
        if (md == 2'd3 || n == 0 || (md == 2'd0 && s == 128'd0) || (md == 2'd2 && !ARITH_EN)) begin
            kind = K_ERR;
            return;
        end
        delta = (md == 2'd0) ? n : n + 1;
        for (int j = 1; j <= ((md == 2'd0) ? n - 1 : n); j++) begin
            jj = 128'(j);
            if (md == 2'd0)      term = s * fib[j + 1];
            else if (md == 2'd1) term = s + jj * (jj + 128'd1) / 128'd2;
            else                 term = s + jj * stp;
            if (term >= lim) begin
                kind  = K_OVF;
                delta = j;
                val   = top[63:0];
                return;
            end
        end
        jj = 128'(n);
        if (md == 2'd0)      term = s * fib[n];
        else if (md == 2'd1) term = s + jj * (jj + 128'd1) / 128'd2;
        else                 term = s + jj * stp;
        val = term[63:0];
    endfunction

    task automatic mon_one(input int d, input logic dn, input logic ov, input logic ovp,
                           input logic er, input logic erp, input logic [63:0] dv);
        logic [1:0] k;
        exp_t e;
        if (dn || (ov && !ovp) || (er && !erp)) begin
            k = dn ? K_DONE : ((ov && !ovp) ? K_OVF : K_ERR);
            checks++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL unexpected_event dut%0d: kind %0d data %0h at cycle %0d, none expected",
                         d, k, dv, cyc);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                if (k !== e.kind || dv !== e.val || cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL scoreboard dut%0d: got kind %0d data %0h cycle %0d, expected kind %0d data %0h cycle %0d",
                             d, k, dv, cyc, e.kind, e.val, e.cyc);
                end
            end
        end
    endtask

    // Monitor: compare every response the instances present.
    always @(negedge clk) begin
        mon_one(0, done0, ovf0, ovf0_p, err0, err0_p, dout0);
        mon_one(1, done1, ovf1, ovf1_p, err1, err1_p, {56'd0, dout1});
        ovf0_p <= ovf0;
        err0_p <= err0;
        ovf1_p <= ovf1;
        err1_p <= err1;
    end

    // Issue one request; abort_at>0 clears it at edge E(abort_at) if still running.
    task automatic do_req(input int d, input logic [1:0] md, input int n, input logic [63:0] sd,
                          input logic [63:0] st, input int abort_at, input int hold);
        logic [1:0]  k;
        logic [63:0] v;
        int          dl;
        logic [31:0] c0;
        logic [3:0]  f;
        exp_t        e;
        bit          aborted;
        model(d, md, n, sd, st, k, v, dl);
        aborted = (abort_at > 0) && (abort_at < dl) && (k != K_ERR);
        mode_i  = md;
        order_i = n[15:0];
        data_i  = sd;
        step_i  = st;
        if (d == 0) start0 = 1'b1;
        else        start1 = 1'b1;
        c0 = cyc + 32'd1;
        if (!aborted) begin
            e.kind = k;
            e.val  = v;
            e.cyc  = c0 + 32'(dl);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        f = flags(d);
        if (k != K_ERR) chk("busy_after_start", {63'd0, f[3]}, 64'd1);
        if (aborted) begin
            while (cyc < c0 + 32'(abort_at) - 32'd1) @(negedge clk);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            chk("abort_flags", {60'd0, flags(d)}, 64'd0);
            chk("abort_data", dout(d), 64'd0);
            repeat (4) @(negedge clk);
        end else begin
            for (int i = 0; i < dl + 8 && !ev(d); i++) @(negedge clk);
            f = flags(d);
            if (!ev(d)) begin
                checks++;
                errors++;
                $display("FAIL timeout dut%0d: no response within %0d cycles, expected kind %0d", d, dl + 8, k);
                if (d == 0) q0.delete();
                else        q1.delete();
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
            end else if (f[2]) begin
                @(negedge clk);
            end else begin
                repeat (hold) @(negedge clk);
                f = flags(d);
                chk("sticky_flags", {62'd0, f[1:0]}, (k == K_OVF) ? 64'd2 : 64'd1);
                chk("sticky_data", dout(d), (k == K_OVF) ? v : 64'd0);
                clear = 1'b1;
                @(negedge clk);
                clear = 1'b0;
                chk("cleared_flags", {60'd0, flags(d)}, 64'd0);
                chk("cleared_data", dout(d), 64'd0);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          d, r, n, ab;
        logic [1:0]  md;
        logic [63:0] sd, st;
        fib[0] = 128'd0;
        fib[1] = 128'd1;
        for (int i = 2; i <= 100; i++) fib[i] = fib[i - 1] + fib[i - 2];

        repeat (2) @(negedge clk);
        chk("reset_flags0", {60'd0, flags(0)}, 64'd0);
        chk("reset_data0", dout(0), 64'd0);
        chk("reset_flags1", {60'd0, flags(1)}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases
        do_req(0, 2'd0, 10, 64'd1, 64'd0, 0, 0);     // 55 at E10
        do_req(0, 2'd1, 100, 64'd0, 64'd0, 0, 0);    // 5050 at E101
        do_req(0, 2'd1, 100, 64'd7, 64'd0, 0, 0);    // 5057
        do_req(1, 2'd0, 13, 64'd1, 64'd0, 0, 0);     // 233
        do_req(1, 2'd0, 14, 64'd1, 64'd0, 0, 3);     // overflow, held
        do_req(0, 2'd0, 0, 64'd5, 64'd0, 0, 2);      // order 0 in each mode
        do_req(0, 2'd1, 0, 64'd5, 64'd0, 0, 0);
        do_req(0, 2'd2, 0, 64'd5, 64'd1, 0, 1);
        do_req(0, 2'd3, 0, 64'd5, 64'd0, 0, 0);
        do_req(0, 2'd0, 5, 64'd0, 64'd0, 0, 2);      // Fibonacci seed 0
        do_req(0, 2'd3, 5, 64'd5, 64'd0, 0, 1);      // reserved mode
        do_req(1, 2'd3, 5, 64'd5, 64'd0, 0, 1);
        do_req(0, 2'd2, 4, 64'd5, 64'd3, 0, 2);      // 17 at E5, or ERR
        do_req(0, 2'd0, 20, 64'd1, 64'd0, 3, 0);     // abort at E3
        do_req(0, 2'd0, 20, 64'd1, 64'd0, 0, 0);     // 6765 afterwards

        // clear wins over start in the same cycle
        mode_i = 2'd0; order_i = 16'd5; data_i = 64'd1;
        start0 = 1'b1;
        clear  = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        clear  = 1'b0;
        chk("clear_beats_start", {60'd0, flags(0)}, 64'd0);
        repeat (8) @(negedge clk);

        // asynchronous reset in the middle of a run
        mode_i = 2'd1; order_i = 16'd150; data_i = 64'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_before_reset", {63'd0, busy0}, 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_midrun_flags", {60'd0, flags(0)}, 64'd0);
        chk("reset_midrun_data", dout(0), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_req(0, 2'd1, 10, 64'd3, 64'd0, 0, 0);     // 58 after reset

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            md = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            case (md)
                2'd0:    n = int'((d == 0) ? $urandom_range(0, 90) : $urandom_range(0, 16));
                2'd1:    n = int'((d == 0) ? $urandom_range(0, 200) : $urandom_range(0, 30));
                2'd2:    n = int'($urandom_range(0, 40));
                default: n = int'($urandom_range(0, 10));
            endcase
            if ($urandom_range(0, 9) == 0) n = 0;
            r = int'($urandom_range(0, 3));
            if (r == 0)      sd = {$urandom(), $urandom()};
            else if (r == 1) sd = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 5000));
            else             sd = 64'($urandom_range(0, 50));
            st = ($urandom_range(0, 2) == 0) ? {$urandom(), $urandom()} : 64'($urandom_range(0, 20));
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 30)) : 0;
            do_req(d, md, n, sd, st, ab, int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: %0d and %0d responses never seen, expected 0",
                     q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
